fp_div_sched: RTL and testbench

Round-robin scheduler that shares one combinational single-precision divider (`fp_div`) among `NUM_REQ` requesters. Each accepted operand pair is registered and held stable for `EXEC_CYCLES` cycles, so the divider can be timed as a multicycle path. The result is then returned on a single tagged response channel with backpressure. The block sits between the FPU issue logic and the shared divide datapath.

---
 rtl/fp_div_sched_pkg.sv | 18 +
 rtl/fp_div.sv | 89 ++++++++
 rtl/fp_div_sched_rr_arbiter.sv | 31 +++
 rtl/fp_div_sched.sv | 128 ++++++++++++
 tb/tb_fp_div_sched.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_div_sched_pkg.sv
// Shared types and helpers for the fp_div_sched slice.
// Holds the FSM state enum, the default requester count and width helpers.
package fp_div_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

    localparam int DEF_NUM_REQ = 4;

    // Width of an index over n items, never below one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fp_div.sv
// Combinational IEEE-754 single-precision divider, round to nearest even.
// Ports: i_a dividend, i_b divisor, o_res quotient, o_overflow finite overflow.
// Subnormal inputs are treated as zero; underflowing results flush to zero.
module fp_div (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_res,
    output logic        o_overflow
);

    logic        w_sign;
    logic [7:0]  w_ea;
    logic [7:0]  w_eb;
    logic        w_a_zero;
    logic        w_b_zero;
    logic        w_a_inf;
    logic        w_b_inf;
    logic        w_nan;
    logic [23:0] w_ma;
    logic [23:0] w_mb;
    logic [49:0] w_num;
    logic [49:0] w_den;
    logic [26:0] w_q;
    logic        w_rem_nz;
    logic [23:0] w_mant;
    logic        w_guard;
    logic        w_sticky;
    logic [24:0] w_mant_r;
    logic [22:0] w_frac;
    logic signed [9:0] w_exp;

    assign w_sign   = i_a[31] ^ i_b[31];
    assign w_ea     = i_a[30:23];
    assign w_eb     = i_b[30:23];
    assign w_a_zero = (w_ea == 8'h00);
    assign w_b_zero = (w_eb == 8'h00);
    assign w_a_inf  = (w_ea == 8'hFF) && (i_a[22:0] == '0);
    assign w_b_inf  = (w_eb == 8'hFF) && (i_b[22:0] == '0);
    assign w_nan    = ((w_ea == 8'hFF) && (i_a[22:0] != '0))
                    || ((w_eb == 8'hFF) && (i_b[22:0] != '0))
                    || (w_a_zero && w_b_zero)
                    || (w_a_inf && w_b_inf);

    // Hidden bit forced to 1 so the divisor is never zero.
    assign w_ma  = {1'b1, i_a[22:0]};
    assign w_mb  = {1'b1, i_b[22:0]};
    assign w_num = {w_ma, 26'b0};
    assign w_den = {26'b0, w_mb};

    // Ratio lies in (0.5, 2): quotient has 26 or 27 significant bits.
    assign w_q      = 27'(w_num / w_den);
    assign w_rem_nz = (w_num % w_den) != '0;

    always_comb begin
        if (w_q[26]) begin
            w_mant   = w_q[26:3];
            w_guard  = w_q[2];
            w_sticky = (|w_q[1:0]) | w_rem_nz;
        end else begin
            w_mant   = w_q[25:2];
            w_guard  = w_q[1];
            w_sticky = w_q[0] | w_rem_nz;
        end
        w_mant_r = {1'b0, w_mant}
                 + {24'b0, w_guard & (w_sticky | w_mant[0])};
        w_frac   = w_mant_r[24] ? w_mant_r[23:1] : w_mant_r[22:0];
        w_exp    = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb})
                 + (w_q[26] ? 10'sd127 : 10'sd126)
                 + (w_mant_r[24] ? 10'sd1 : 10'sd0);
    end

    always_comb begin
        o_overflow = 1'b0;
        o_res      = {w_sign, w_exp[7:0], w_frac};
        if (w_nan) begin
            o_res = 32'h7FC0_0000;
        end else if (w_a_inf || w_b_zero) begin
            o_res = {w_sign, 8'hFF, 23'h0};
        end else if (w_a_zero || w_b_inf) begin
            o_res = {w_sign, 31'h0};
        end else if (w_exp >= 10'sd255) begin
            o_res      = {w_sign, 8'hFF, 23'h0};
            o_overflow = 1'b1;
        end else if (w_exp <= 10'sd0) begin
            o_res = {w_sign, 31'h0};
        end
    end

endmodule

// File: rtl/fp_div_sched_rr_arbiter.sv
// Combinational round-robin arbiter, search starts at i_ptr and wraps.
// Ports: i_req request vector, i_ptr start index, o_grant one-hot,
// o_idx binary winner, o_any some request present.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [N-1:0]   o_grant,
    output logic [IDW-1:0] o_idx,
    output logic           o_any
);

    always_comb begin
        int j;
        j       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[j]) begin
                o_any      = 1'b1;
                o_idx      = IDW'(j);
                o_grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_div_sched.sv
// Round-robin scheduler sharing one multicycle fp_div among NUM_REQ requesters.
// Ports: req_* per-requester valid/operands/grant, resp_* tagged result
// channel with backpressure, busy (not idle), op_count completed responses.
module fp_div_sched
    import fp_div_sched_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int EXEC_CYCLES = 2,
    parameter int ID_W        = clog2_min1(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0][31:0] req_opd1,
    input  logic [NUM_REQ-1:0][31:0] req_opd2,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [31:0]             resp_res,
    output logic                    resp_overflow,
    output logic                    busy,
    output logic [31:0]             op_count
);

    localparam int CNT_W = clog2_min1(EXEC_CYCLES + 1);
    // Divider gets EXEC_CYCLES full cycles after the operand launch cycle.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES);

    sched_state_t     r_state;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_id;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_opd1;
    logic [31:0]      r_opd2;
    logic             r_resp_valid;
    logic [ID_W-1:0]  r_resp_id;
    logic [31:0]      r_resp_res;
    logic             r_resp_ovf;
    logic [31:0]      r_op_count;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic [31:0]        w_res;
    logic               w_ovf;

    rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (ID_W)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    fp_div u_div (
        .i_a        (r_opd1),
        .i_b        (r_opd2),
        .o_res      (w_res),
        .o_overflow (w_ovf)
    );

    assign w_ptr_nxt = (w_idx == ID_W'(NUM_REQ - 1))
                     ? '0 : w_idx + ID_W'(1);

    // Grant is withheld while reset is asserted so no request sees a
    // handshake that the FSM will not honour.
    assign req_ready     = ((r_state == IDLE) && rst_n) ? w_grant : '0;
    assign busy          = (r_state != IDLE);
    assign resp_valid    = r_resp_valid;
    assign resp_id       = r_resp_id;
    assign resp_res      = r_resp_res;
    assign resp_overflow = r_resp_ovf;
    assign op_count      = r_op_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_id         <= '0;
            r_cnt        <= '0;
            r_opd1       <= '0;
            r_opd2       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_res   <= '0;
            r_resp_ovf   <= 1'b0;
            r_op_count   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_opd1  <= req_opd1[w_idx];
                        r_opd2  <= req_opd2[w_idx];
                        r_id    <= w_idx;
                        r_cnt   <= CNT_LOAD;
                        r_ptr   <= w_ptr_nxt;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_cnt == '0) begin
                        r_resp_res   <= w_res;
                        r_resp_ovf   <= w_ovf;
                        r_resp_id    <= r_id;
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_op_count   <= r_op_count + 32'd1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_sched.sv
// Scoreboard bench for fp_div_sched: real-arithmetic divide model,
// round-robin grant model, directed and randomized traffic.
module tb_fp_div_sched;

    localparam int NR  = 4;
    localparam int EC  = 2;
    localparam int IDW = 2;
    localparam int HP  = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NR-1:0]       req_valid = '0;
    logic [NR-1:0][31:0] req_opd1 = '0;
    logic [NR-1:0][31:0] req_opd2 = '0;
    logic [NR-1:0]       req_ready;
    logic                resp_valid;
    logic                resp_ready = 1'b0;
    logic [IDW-1:0]      resp_id;
    logic [31:0]         resp_res;
    logic                resp_overflow;
    logic                busy;
    logic [31:0]         op_count;

    always #HP clk = ~clk;

    fp_div_sched #(
        .NUM_REQ     (NR),
        .EXEC_CYCLES (EC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_opd1      (req_opd1),
        .req_opd2      (req_opd2),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_res      (resp_res),
        .resp_overflow (resp_overflow),
        .busy          (busy),
        .op_count      (op_count)
    );

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        ovf;
        time         tacc;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] rq[NR][$];
    int          gnt_log[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          mptr = 0;
    bit          mbusy = 1'b0;
    logic [31:0] exp_cnt = '0;
    int          bp_hold = 0;
    bit          rand_bp = 1'b0;
    int          nresp = 0;
    logic [31:0] last_res = '0;
    int          last_id = 0;
    logic        last_ovf = 1'b0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic int pick(logic [NR-1:0] v, int p);
        for (int k = 0; k < NR; k++)
            if (v[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    function automatic real mag(logic [31:0] x);
        logic [63:0] d;
        d = {1'b0, 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    // Returns {overflow, quotient}.
    function automatic logic [32:0] ref_div(logic [31:0] a, logic [31:0] b);
        logic        s;
        bit          an, bn, ai, bi, az, bz;
        real         q;
        logic [63:0] d;
        int          se;
        logic [24:0] m;
        s  = a[31] ^ b[31];
        an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        az = (a[30:23] == 8'h00);
        bz = (b[30:23] == 8'h00);
        if (an || bn || (az && bz) || (ai && bi)) return {1'b0, 32'h7FC0_0000};
        if (ai || bz) return {1'b0, s, 8'hFF, 23'h0};
        if (az || bi) return {1'b0, s, 31'h0};
        q  = mag(a) / mag(b);
        d  = $realtobits(q);
        se = int'(d[62:52]) - 1023 + 127;
        m  = {2'b01, d[51:29]};
        if (d[28] && ((|d[27:0]) || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            se++;
        end
        if (se >= 255) return {1'b1, s, 8'hFF, 23'h0};
        if (se <= 0) return {1'b0, s, 31'h0};
        return {1'b0, s, 8'(se), m[22:0]};
    endfunction

    function automatic logic [31:0] gen_fp();
        logic [31:0] v;
        int          r;
        r = $urandom_range(0, 15);
        v = $urandom;
        if (r == 0) begin
            case ($urandom_range(0, 5))
                0: v = 32'h0000_0000;
                1: v = 32'h8000_0000;
                2: v = 32'h7F80_0000;
                3: v = 32'hFF80_0000;
                4: v = 32'h7FC0_0000;
                default: v = 32'h0000_0001;
            endcase
        end else if (r < 4) begin
            v[30:23] = 8'($urandom_range(1, 254));
        end else begin
            v[30:23] = 8'($urandom_range(100, 154));
        end
        return v;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < NR; i++)
            if (rq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // ---------------- requester driver ----------------
    always @(negedge clk) begin : drv
        logic [NR-1:0] acc;
        logic [NR-1:0] expr;
        logic [32:0]   r;
        exp_t          e;
        int            w;
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = rq[i].size() > 0;
            if (req_valid[i]) begin
                req_opd1[i] = rq[i][0][63:32];
                req_opd2[i] = rq[i][0][31:0];
            end else begin
                req_opd1[i] = $urandom;
                req_opd2[i] = $urandom;
            end
        end
        #1;
        if (rst_n) begin
            w    = pick(req_valid, mptr);
            expr = '0;
            if (!mbusy && w >= 0) expr[w] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(expr));
        end
        acc = req_valid & req_ready;
        @(posedge clk);
        if (rst_n && acc != '0) begin
            w = 0;
            for (int i = 0; i < NR; i++) if (acc[i]) w = i;
            r      = ref_div(rq[w][0][63:32], rq[w][0][31:0]);
            void'(rq[w].pop_front());
            e.id   = w;
            e.res  = r[31:0];
            e.ovf  = r[32];
            e.tacc = $time;
            sb.push_back(e);
            gnt_log.push_back(w);
            mptr  = (w + 1) % NR;
            mbusy = 1'b1;
        end
    end

    // ---------------- response monitor ----------------
    bit          prev_v = 1'b0;
    int          hold = 0;
    logic [31:0] cur_res;
    logic [IDW-1:0] cur_id;
    logic        cur_ovf;

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            prev_v     = 1'b0;
            hold       = 0;
            resp_ready = 1'b0;
        end else begin
            chk("busy", 64'(busy), 64'(mbusy));
            if (resp_valid) begin
                chk("op_count", 64'(op_count), 64'(exp_cnt));
                if (!prev_v) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        $display("FAIL resp_spurious: got id %0d res %h, none expected",
                                 resp_id, resp_res);
                    end else begin
                        e = sb.pop_front();
                        chk("resp_id", 64'(resp_id), 64'(e.id));
                        chk("resp_res", 64'(resp_res), 64'(e.res));
                        chk("resp_overflow", 64'(resp_overflow), 64'(e.ovf));
                        chk("latency", 64'($time - HP - e.tacc), 64'((EC + 1) * 2 * HP));
                    end
                    cur_res  = resp_res;
                    cur_id   = resp_id;
                    cur_ovf  = resp_overflow;
                    last_res = resp_res;
                    last_id  = int'(resp_id);
                    last_ovf = resp_overflow;
                    hold     = bp_hold;
                    bp_hold  = 0;
                end else begin
                    chk("hold_res", 64'(resp_res), 64'(cur_res));
                    chk("hold_id", 64'(resp_id), 64'(cur_id));
                    chk("hold_ovf", 64'(resp_overflow), 64'(cur_ovf));
                end
                prev_v = 1'b1;
                if (hold > 0) begin
                    resp_ready = 1'b0;
                    hold--;
                end else begin
                    resp_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (resp_ready) begin
                    @(posedge clk);
                    if (rst_n) begin
                        exp_cnt = exp_cnt + 32'd1;
                        mbusy   = 1'b0;
                        nresp++;
                    end
                    prev_v = 1'b0;
                end
            end else begin
                prev_v     = 1'b0;
                resp_ready = 1'b0;
            end
        end
    end

    // ---------------- sequencing ----------------
    task automatic flush_model();
        sb.delete();
        for (int i = 0; i < NR; i++) rq[i].delete();
        mbusy   = 1'b0;
        mptr    = 0;
        exp_cnt = '0;
        bp_hold = 0;
        rand_bp = 1'b0;
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_op_count"}, 64'(op_count), 64'd0);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_resp_id"}, 64'(resp_id), 64'd0);
        chk({tag, "_resp_res"}, 64'(resp_res), 64'd0);
        chk({tag, "_resp_ovf"}, 64'(resp_overflow), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        flush_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(int budget);
        int c;
        c = 0;
        while (!(all_empty() && sb.size() == 0 && !mbusy) && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (c >= budget) begin
            n_chk++;
            $display("FAIL timeout: scheduler idle not reached in %0d cycles", budget);
        end
        @(negedge clk);
    endtask

    initial begin : wdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int nb;
        int c;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // single operation on requester 2
        rq[2].push_back({32'h3F80_0000, 32'h4000_0000});
        wait_done(200);
        chk("single_id", 64'(last_id), 64'd2);
        chk("single_res", 64'(last_res), 64'h3F00_0000);
        chk("single_ovf", 64'(last_ovf), 64'd0);

        // backpressure for 5 cycles
        bp_hold = 5;
        rq[1].push_back({32'h40C0_0000, 32'h4040_0000});
        wait_done(200);
        chk("bp_res", 64'(last_res), 64'h4000_0000);
        chk("bp_op_count", 64'(op_count), 64'd2);

        // fairness with all four requesters busy
        do_reset();
        gnt_log.delete();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NR; i++)
                rq[i].push_back({gen_fp(), gen_fp()});
        wait_done(400);
        for (int k = 0; k < 8; k++)
            chk($sformatf("fair_order%0d", k), 64'(gnt_log[k]), 64'(k % NR));

        // overflow
        rq[1].push_back({32'h7F00_0000, 32'h0080_0000});
        wait_done(200);
        chk("ovf_flag", 64'(last_ovf), 64'd1);
        chk("ovf_id", 64'(last_id), 64'd1);

        // randomized traffic with random backpressure
        rand_bp = 1'b1;
        for (int n = 0; n < 60; n++) begin
            rq[$urandom_range(0, NR - 1)].push_back({gen_fp(), gen_fp()});
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 8)) @(negedge clk);
        end
        wait_done(5000);
        rand_bp = 1'b0;

        // reset while in EXEC
        rq[3].push_back({gen_fp(), gen_fp()});
        c = 0;
        do begin
            @(posedge clk);
            #2;
            c++;
        end while (!(mbusy && !resp_valid) && c < 100);
        if (c >= 100) begin
            n_chk++;
            $display("FAIL exec_wait: EXEC never reached");
        end
        rst_n = 1'b0;
        flush_model();
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nb = nresp;
        repeat (6) @(negedge clk);
        chk("no_resp_after_rst", 64'(nresp), 64'(nb));
        gnt_log.delete();
        @(posedge clk);
        #1;
        rq[3].push_back({gen_fp(), gen_fp()});
        rq[0].push_back({gen_fp(), gen_fp()});
        wait_done(200);
        chk("rst_first_grant", 64'(gnt_log[0]), 64'd0);
        chk("rst_second_grant", 64'(gnt_log[1]), 64'd3);

        // op_count wrap
        @(negedge clk);
        force dut.r_op_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_op_count;
        exp_cnt = 32'hFFFF_FFFF;
        chk("wrap_preset", 64'(op_count), 64'hFFFF_FFFF);
        rq[2].push_back({32'h4040_0000, 32'h3F80_0000});
        wait_done(200);
        chk("wrap_op_count", 64'(op_count), 64'd0);
        chk("wrap_res", 64'(last_res), 64'h4040_0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
